coalesce_sequencer: RTL and testbench
=====================================

# coalesce_sequencer

Per-warp memory coalescing sequencer that sits between the address-generation stage and the memory stage-2 / cache latency emulator. It accepts one warp-wide load/store (8 thread addresses plus an active mask), then issues one 27-bit cache-line address per cycle until every active thread has been covered. Each issued line carries the mask of threads it serves. Issue holds whenever the cache reports a miss wait or downstream backpressures.

## Interface
- `NUM_THREADS`, default 8: threads per warp; only 8 is supported.
- `LINE_BITS`, default 5: byte-offset bits per cache line; line address = `addr[31:LINE_BITS]`, width 27.
- `clk` input 1: clock, rising edge.
- `resetb` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: warp request present.
- `req_ready` output 1: sequencer can accept; high only in IDLE.
- `req_MemRead`, `req_MemWrite`, `req_shared_global_bar` input 1 each: access type, captured on accept.
- `req_warp_ID` input 3, `req_scb_ID` input 2, `req_reg_addr` input 5, `req_Instr` input 32: tags, captured on accept.
- `req_PAM` input 8: active thread mask.
- `req_eff_addr` input 256: thread i address at bits `[32i+31:32i]`.
- `stall` input 1: hold current issue; this is the cache `miss_wait` ORed with downstream stall.
- `issue_valid` output 1: `addr_sel`/tags valid this cycle.
- `addr_sel` output 27: line address being issued.
- `issue_mask` output 8: threads whose line equals `addr_sel`.
- `issue_last` output 1: final line of the warp.
- `MemRead_o`, `MemWrite_o`, `shared_global_bar_o`, `warp_ID_o`, `scb_ID_o`, `reg_addr_o`, `Instr_o`: captured tags, held stable for the whole warp.
- `PAM_o` output 8: captured PAM.
- `eff_addr_o` output 256: captured addresses.
- `done` output 1: one-cycle pulse when the warp completes.

## Operation
- **States:** IDLE, ISSUE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture all `req_*` inputs into registers and load `pending` = `req_PAM`.
  - If `req_PAM`≠0, go to ISSUE.
  - If `req_PAM`=0, pulse `done` next cycle and stay in IDLE; no issue occurs.
- **ISSUE:**
  - `leader` = lowest-index set bit of `pending`.
  - `addr_sel` = `addr[leader][31:LINE_BITS]`.
  - `issue_mask[i]` = `pending[i]` AND (line of thread i == `addr_sel`).
  - `issue_last` = (`pending` & ~`issue_mask`)==0.
  - `issue_valid`=1.
- **Issue accepted** (`issue_valid` & !`stall`):
  - `pending` <= `pending` & ~`issue_mask`.
  - If `issue_last`, go to IDLE and pulse `done` in the following cycle.
- **Stall:** while `stall`=1, `pending`, `addr_sel`, `issue_mask` and `issue_last` hold unchanged.
- **Combinational outputs:** `addr_sel`, `issue_mask` and `issue_last` derive combinationally from registered `pending` and addresses. Tags are registered.
- **Line count:** distinct lines = number of issues, 1..8.
- **Duplicates:** threads sharing a line are always served by the same issue, regardless of word offset.
- **Reset values:**
  - State=IDLE, `pending`=0.
  - All tag registers 0, `issue_valid`=0, `done`=0, `req_ready`=1.
  - `addr_sel`=0 and `issue_mask`=0 while IDLE.
- **Reset mid-warp:** the warp is abandoned immediately and no `done` is produced.

## Timing
- **Accept to first issue:** 1 cycle. Accept on edge N; `issue_valid` in cycle N+1.
- **Unstalled throughput:** one line per cycle. A warp with k lines occupies ISSUE for k cycles plus stall cycles.
- **`done`:** asserted the cycle after the last accepted issue. `req_ready` rises in that same cycle, so a back-to-back warp may be accepted then.
- **No overlap:** a new request is never accepted while in ISSUE.
- **Stall on last line:** `issue_last` stays high and `done` is deferred.
- **`stall` in IDLE:** ignored.

## Configuration
- **`COALESCE_PERF_CNT_EN` defined:**
  - Adds output `perf_lines` (16 bits), which counts accepted issues.
  - Adds output `perf_warps` (16 bits), which counts `done` pulses.
  - Both counters saturate at 0xFFFF and reset to 0.
- **`COALESCE_PERF_CNT_EN` not defined:** both ports and counters are absent; all other behaviour is identical.

## Test plan
- All 8 threads active, addresses 0x100+4i (one line), no stall → one issue: `addr_sel`=0x8, `issue_mask`=0xFF, `issue_last`=1; `done` one cycle later.
- PAM=0xFF, thread i at 0x1000+32i → 8 issues over 8 consecutive cycles: `addr_sel`=0x80..0x87, `issue_mask`=0x01,0x02,…,0x80; `issue_last` only on the 8th.
- PAM=0xA5, threads 0 and 7 in line 0x10, threads 2 and 5 in line 0x20 → issue 1: `addr_sel`=0x10, mask 0x81; issue 2: `addr_sel`=0x20, mask 0x24, last=1.
- Two-line warp with `stall` high for 3 cycles during the first issue → outputs stable for those 3 cycles; second issue follows on the cycle after stall drops; `done` total latency 6 cycles from accept.
- PAM=0x00 → no `issue_valid`; `done` pulses on cycle 1 after accept; `req_ready` never drops.
- `resetb` asserted during the second issue of a 4-line warp → next cycle: `issue_valid`=0, `req_ready`=1, no `done`; a new warp is then accepted normally.

Source files
------------

// File: rtl/coalesce_sequencer.sv
// Warp memory coalescing sequencer: it accepts one warp request, then issues one cache-line address per cycle.
// Optional build macro COALESCE_PERF_CNT_EN adds the saturating perf_lines/perf_warps counters.
module coalesce_sequencer #(
   parameter int NUM_THREADS = 8,
   parameter int LINE_BITS   = 5
) (
   input  logic                        clk,
   input  logic                        resetb,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_MemRead,
   input  logic                        req_MemWrite,
   input  logic                        req_shared_global_bar,
   input  logic [2:0]                  req_warp_ID,
   input  logic [1:0]                  req_scb_ID,
   input  logic [4:0]                  req_reg_addr,
   input  logic [31:0]                 req_Instr,
   input  logic [NUM_THREADS-1:0]      req_PAM,
   input  logic [32*NUM_THREADS-1:0]   req_eff_addr,
   input  logic                        stall,
   output logic                        issue_valid,
   output logic [31-LINE_BITS:0]       addr_sel,
   output logic [NUM_THREADS-1:0]      issue_mask,
   output logic                        issue_last,
   output logic                        MemRead_o,
   output logic                        MemWrite_o,
   output logic                        shared_global_bar_o,
   output logic [2:0]                  warp_ID_o,
   output logic [1:0]                  scb_ID_o,
   output logic [4:0]                  reg_addr_o,
   output logic [31:0]                 Instr_o,
   output logic [NUM_THREADS-1:0]      PAM_o,
   output logic [32*NUM_THREADS-1:0]   eff_addr_o,
   output logic                        done
`ifdef COALESCE_PERF_CNT_EN
   ,
   output logic [15:0]                 perf_lines,
   output logic [15:0]                 perf_warps
`endif
);

   localparam int LINE_W   = 32 - LINE_BITS;
   localparam int LEADER_W = $clog2(NUM_THREADS);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                           state_q, state_d;
   logic [NUM_THREADS-1:0]           pending_q, pending_d;
   logic                             done_q, done_d;
   logic                             capture;
   logic [LEADER_W-1:0]              leader;
   logic [NUM_THREADS-1:0][LINE_W-1:0] line_of;
   logic                             issue_fire;

   // Lowest-index pending thread leads; scanning downward lets the lowest set bit win.
   always_comb begin
      leader = '0;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (pending_q[i]) leader = LEADER_W'(i);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         line_of[i] = eff_addr_o[32*i+LINE_BITS +: LINE_W];
      end
   end

   assign issue_valid = (state_q == ISSUE);
   assign req_ready   = (state_q == IDLE);
   assign addr_sel    = issue_valid ? line_of[leader] : '0;
   assign issue_fire  = issue_valid && !stall;
   assign done        = done_q;

   // Every pending thread on the leader's line is served together, whatever its word offset.
   always_comb begin
      issue_mask = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         issue_mask[i] = issue_valid && pending_q[i] && (line_of[i] == line_of[leader]);
      end
   end

   assign issue_last = issue_valid && ((pending_q & ~issue_mask) == '0);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               capture   = 1'b1;
               pending_d = req_PAM;
               if (req_PAM != '0) state_d = ISSUE;
               else               done_d  = 1'b1;
            end
         end
         ISSUE: begin
            if (issue_fire) begin
               pending_d = pending_q & ~issue_mask;
               if (issue_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q             <= IDLE;
         pending_q           <= '0;
         done_q              <= 1'b0;
         MemRead_o           <= 1'b0;
         MemWrite_o          <= 1'b0;
         shared_global_bar_o <= 1'b0;
         warp_ID_o           <= '0;
         scb_ID_o            <= '0;
         reg_addr_o          <= '0;
         Instr_o             <= '0;
         PAM_o               <= '0;
         // NOTE: the address capture is a plain register bank, so it is reset like the tags.
         eff_addr_o          <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         done_q    <= done_d;
         if (capture) begin
            MemRead_o           <= req_MemRead;
            MemWrite_o          <= req_MemWrite;
            shared_global_bar_o <= req_shared_global_bar;
            warp_ID_o           <= req_warp_ID;
            scb_ID_o            <= req_scb_ID;
            reg_addr_o          <= req_reg_addr;
            Instr_o             <= req_Instr;
            PAM_o               <= req_PAM;
            eff_addr_o          <= req_eff_addr;
         end
      end
   end

`ifdef COALESCE_PERF_CNT_EN
   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         perf_lines <= '0;
         perf_warps <= '0;
      end else begin
         if (issue_fire && (perf_lines != 16'hFFFF)) perf_lines <= perf_lines + 16'd1;
         if (done_q && (perf_warps != 16'hFFFF))     perf_warps <= perf_warps + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_coalesce_sequencer.sv
// Directed bench for coalesce_sequencer: expected issues are queued on stimulus and popped as the DUT issues.
module tb_coalesce_sequencer;

   logic         clk = 1'b0;
   logic         resetb;
   logic         req_valid;
   logic         req_ready;
   logic         req_MemRead, req_MemWrite, req_shared_global_bar;
   logic [2:0]   req_warp_ID;
   logic [1:0]   req_scb_ID;
   logic [4:0]   req_reg_addr;
   logic [31:0]  req_Instr;
   logic [7:0]   req_PAM;
   logic [255:0] req_eff_addr;
   logic         stall;
   logic         issue_valid;
   logic [26:0]  addr_sel;
   logic [7:0]   issue_mask;
   logic         issue_last;
   logic         MemRead_o, MemWrite_o, shared_global_bar_o;
   logic [2:0]   warp_ID_o;
   logic [1:0]   scb_ID_o;
   logic [4:0]   reg_addr_o;
   logic [31:0]  Instr_o;
   logic [7:0]   PAM_o;
   logic [255:0] eff_addr_o;
   logic         done;
`ifdef COALESCE_PERF_CNT_EN
   logic [15:0]  perf_lines, perf_warps;
`endif

   coalesce_sequencer dut (
      .clk(clk), .resetb(resetb),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_MemRead(req_MemRead), .req_MemWrite(req_MemWrite),
      .req_shared_global_bar(req_shared_global_bar),
      .req_warp_ID(req_warp_ID), .req_scb_ID(req_scb_ID),
      .req_reg_addr(req_reg_addr), .req_Instr(req_Instr),
      .req_PAM(req_PAM), .req_eff_addr(req_eff_addr),
      .stall(stall),
      .issue_valid(issue_valid), .addr_sel(addr_sel),
      .issue_mask(issue_mask), .issue_last(issue_last),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .shared_global_bar_o(shared_global_bar_o),
      .warp_ID_o(warp_ID_o), .scb_ID_o(scb_ID_o),
      .reg_addr_o(reg_addr_o), .Instr_o(Instr_o),
      .PAM_o(PAM_o), .eff_addr_o(eff_addr_o),
      .done(done)
`ifdef COALESCE_PERF_CNT_EN
      , .perf_lines(perf_lines), .perf_warps(perf_warps)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [26:0] addr;
      logic [7:0]  mask;
      logic        last;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   logic [2:0]   exp_wid;
   logic [31:0]  exp_instr;
   logic [7:0]   exp_pam;
   logic [255:0] exp_addrs;
   logic [255:0] a;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [26:0] addr, input logic [7:0] mask, input logic last);
      exp_t e;
      e.addr = addr;
      e.mask = mask;
      e.last = last;
      sb.push_back(e);
   endtask

   // Presents one request for a single edge, then scrambles the inputs to prove they were captured.
   task automatic accept(input logic [7:0] pam, input logic [255:0] addrs,
                         input logic [2:0] wid, input logic [31:0] instr);
      req_valid             = 1'b1;
      req_PAM               = pam;
      req_eff_addr          = addrs;
      req_warp_ID           = wid;
      req_Instr             = instr;
      req_MemRead           = instr[0];
      req_MemWrite          = ~instr[0];
      req_shared_global_bar = instr[1];
      req_scb_ID            = instr[3:2];
      req_reg_addr          = instr[8:4];
      exp_pam   = pam;
      exp_addrs = addrs;
      exp_wid   = wid;
      exp_instr = instr;
      check("ready_at_accept", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_PAM      = ~pam;
      req_eff_addr = ~addrs;
      req_warp_ID  = ~wid;
      req_Instr    = ~instr;
   endtask

   // Samples each cycle on the falling edge until done; stall is held for the first nstall issue cycles.
   task automatic drain(input int nstall, input int exp_done_cycle);
      exp_t e;
      bit   fin;
      bit   exp_v;
      int   left;
      fin  = 1'b0;
      left = nstall;
      for (int c = 1; c <= 40 && !fin; c++) begin
         @(negedge clk);
         exp_v = (sb.size() != 0);
         check("issue_valid", {63'd0, issue_valid}, {63'd0, exp_v});
         check("req_ready", {63'd0, req_ready}, {63'd0, !exp_v});
         check("done", {63'd0, done}, {63'd0, !exp_v});
         if (!exp_v) begin
            check("done_cycle", 64'(c), 64'(exp_done_cycle));
            fin = 1'b1;
         end else begin
            e = sb[0];
            check("addr_sel", {37'd0, addr_sel}, {37'd0, e.addr});
            check("issue_mask", {56'd0, issue_mask}, {56'd0, e.mask});
            check("issue_last", {63'd0, issue_last}, {63'd0, e.last});
            check("warp_ID_o", {61'd0, warp_ID_o}, {61'd0, exp_wid});
            check("Instr_o", {32'd0, Instr_o}, {32'd0, exp_instr});
            if (c == 1) begin
               check("PAM_o", {56'd0, PAM_o}, {56'd0, exp_pam});
               check("eff_addr_o", {63'd0, eff_addr_o === exp_addrs}, 64'd1);
               check("MemRead_o", {63'd0, MemRead_o}, {63'd0, exp_instr[0]});
               check("MemWrite_o", {63'd0, MemWrite_o}, {63'd0, ~exp_instr[0]});
               check("sgb_o", {63'd0, shared_global_bar_o}, {63'd0, exp_instr[1]});
               check("scb_ID_o", {62'd0, scb_ID_o}, {62'd0, exp_instr[3:2]});
               check("reg_addr_o", {59'd0, reg_addr_o}, {59'd0, exp_instr[8:4]});
            end
            if (stall) left--;
            else void'(sb.pop_front());
            @(posedge clk);
            #1;
            stall = (left > 0);
         end
      end
      if (!fin) check("drain_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      resetb = 1'b0;
      req_valid = 1'b0; req_PAM = '0; req_eff_addr = '0; req_warp_ID = '0;
      req_Instr = '0; req_MemRead = 1'b0; req_MemWrite = 1'b0;
      req_shared_global_bar = 1'b0; req_scb_ID = '0; req_reg_addr = '0;
      stall = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_addr_sel", {37'd0, addr_sel}, 64'd0);
      check("rst_issue_mask", {56'd0, issue_mask}, 64'd0);
      check("rst_warp_ID_o", {61'd0, warp_ID_o}, 64'd0);
      check("rst_Instr_o", {32'd0, Instr_o}, 64'd0);
      resetb = 1'b1;
      @(negedge clk);

      // One line covering all eight threads.
      for (int i = 0; i < 8; i++) a[32*i +: 32] = 32'h100 + 32'(4*i);
      push(27'h8, 8'hFF, 1'b1);
      accept(8'hFF, a, 3'd1, 32'h0000_0011);
      drain(0, 2);
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);

      // Eight distinct lines, one per cycle.
      for (int i = 0; i < 8; i++) a[32*i +: 32] = 32'h1000 + 32'(32*i);
      for (int i = 0; i < 8; i++) push(27'h80 + 27'(i), 8'(1 << i), i == 7);
      accept(8'hFF, a, 3'd2, 32'h0000_0122);
      drain(0, 9);

      // Back-to-back in the done cycle: PAM 0xA5 with paired duplicates, junk on inactive threads.
      for (int i = 0; i < 8; i++) a[32*i +: 32] = 32'hDEAD_0000 + 32'(i * 32'h100);
      a[0*32 +: 32] = 32'h200;
      a[7*32 +: 32] = 32'h21C;
      a[2*32 +: 32] = 32'h400;
      a[5*32 +: 32] = 32'h410;
      push(27'h10, 8'h81, 1'b0);
      push(27'h20, 8'h24, 1'b1);
      accept(8'hA5, a, 3'd3, 32'h0000_0233);
      drain(0, 3);

      // Two lines with a 3-cycle stall on the first; stall is also high during the accept.
      a = '0;
      a[0*32 +: 32] = 32'h3000;
      a[1*32 +: 32] = 32'h5000;
      push(27'h180, 8'h01, 1'b0);
      push(27'h280, 8'h02, 1'b1);
      stall = 1'b1;
      accept(8'h03, a, 3'd4, 32'h0000_0344);
      drain(3, 6);

      // Empty mask: done without any issue, stall ignored in IDLE.
      stall = 1'b1;
      push(27'h0, 8'h00, 1'b0);
      void'(sb.pop_front());
      accept(8'h00, a, 3'd5, 32'h0000_0455);
      drain(0, 1);
      stall = 1'b0;

      // Reset during the second issue of a four-line warp.
      a = '0;
      for (int i = 0; i < 4; i++) a[32*i +: 32] = 32'h8000 + 32'(64*i);
      accept(8'h0F, a, 3'd6, 32'h0000_0566);
      @(negedge clk);
      check("rst_mid_issue1", {37'd0, addr_sel}, 64'h400);
      @(negedge clk);
      check("rst_mid_issue2", {37'd0, addr_sel}, 64'h402);
      check("rst_mid_mask2", {56'd0, issue_mask}, 64'h02);
      #2 resetb = 1'b0;
      #1;
      check("rst_mid_valid", {63'd0, issue_valid}, 64'd0);
      check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      check("rst_mid_tag", {61'd0, warp_ID_o}, 64'd0);
      @(negedge clk);
      check("rst_mid_done", {63'd0, done}, 64'd0);
      resetb = 1'b1;
      @(negedge clk);
      check("rst_after_done", {63'd0, done}, 64'd0);
      check("rst_after_valid", {63'd0, issue_valid}, 64'd0);

      // New warp accepted normally after the abandoned one.
      for (int i = 0; i < 8; i++) a[32*i +: 32] = 32'h100 + 32'(4*i);
      push(27'h8, 8'h0F, 1'b1);
      accept(8'h0F, a, 3'd7, 32'h0000_0677);
      drain(0, 2);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
